// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: ALU opcodes, operand-select encodings and
// the field values a pipeline bubble carries.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    // A bubble is a non-writing, non-memory ADD of zero operands.
    localparam logic       BUBBLE_CTRL     = 1'b0;
    localparam logic [3:0] BUBBLE_ALU_CTRL = ALU_ADD;
    localparam logic       BUBBLE_OP1_SEL  = OP1_RS1;
    localparam logic       BUBBLE_OP2_SEL  = OP2_RS2;

endpackage

// File: rtl/forward_unit.sv
// Single-operand forwarding mux: EX/MEM beats MEM/WB beats the register
// value captured at decode; x0 is pinned to zero and never forwarded.
module forward_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [XLEN-1:0]   reg_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (src_addr == '0) begin
            fwd_data = '0;
        end else if (exm_reg_write && (exm_rd == src_addr)) begin
            fwd_data = exm_result;
        end else if (wb_reg_write && (wb_rd == src_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: latches decoded instructions,
// resolves operand forwarding and raises the load-use stall.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_op1_sel,
    input  logic              id_op2_sel,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_out,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   alu_data_1,
    output logic [XLEN-1:0]   alu_data_2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_AW-1:0] ex_rd
);

    logic              vld_p1;
    logic              reg_write_p1;
    logic              mem_read_p1;
    logic              mem_write_p1;
    logic [3:0]        alu_ctrl_p1;
    logic              op1_sel_p1;
    logic              op2_sel_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   rs1_data_p1;
    logic [XLEN-1:0]   rs2_data_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [REG_AW-1:0] rs1_p1;
    logic [REG_AW-1:0] rs2_p1;
    logic [REG_AW-1:0] rd_p1;

    logic              kill;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    // Load in EX whose destination decode needs now; suppressed while the
    // pipeline is frozen or being flushed.
    always_comb begin
        stall_out = vld_p1 && mem_read_p1 && (rd_p1 != '0) && id_valid
                    && ((rd_p1 == id_rs1) || (rd_p1 == id_rs2))
                    && !flush_in && !hold_in;
    end

    assign kill = flush_in || stall_out;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= BUBBLE_CTRL;
            reg_write_p1 <= BUBBLE_CTRL;
            mem_read_p1  <= BUBBLE_CTRL;
            mem_write_p1 <= BUBBLE_CTRL;
            alu_ctrl_p1  <= BUBBLE_ALU_CTRL;
            op1_sel_p1   <= BUBBLE_OP1_SEL;
            op2_sel_p1   <= BUBBLE_OP2_SEL;
            pc_p1        <= '0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            imm_p1       <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            rd_p1        <= '0;
        end else if (!hold_in) begin
            if (kill) begin
                vld_p1       <= BUBBLE_CTRL;
                reg_write_p1 <= BUBBLE_CTRL;
                mem_read_p1  <= BUBBLE_CTRL;
                mem_write_p1 <= BUBBLE_CTRL;
                alu_ctrl_p1  <= BUBBLE_ALU_CTRL;
                op1_sel_p1   <= BUBBLE_OP1_SEL;
                op2_sel_p1   <= BUBBLE_OP2_SEL;
                pc_p1        <= '0;
                rs1_data_p1  <= '0;
                rs2_data_p1  <= '0;
                imm_p1       <= '0;
                rs1_p1       <= '0;
                rs2_p1       <= '0;
                rd_p1        <= '0;
            end else begin
                vld_p1       <= id_valid;
                reg_write_p1 <= id_reg_write;
                mem_read_p1  <= id_mem_read;
                mem_write_p1 <= id_mem_write;
                alu_ctrl_p1  <= id_alu_ctrl;
                op1_sel_p1   <= id_op1_sel;
                op2_sel_p1   <= id_op2_sel;
                pc_p1        <= id_pc;
                rs1_data_p1  <= id_rs1_data;
                rs2_data_p1  <= id_rs2_data;
                imm_p1       <= id_imm;
                rs1_p1       <= id_rs1;
                rs2_p1       <= id_rs2;
                rd_p1        <= id_rd;
            end
        end
    end

    // ---- EX operand resolution ----
    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .src_addr      (rs1_p1),
        .reg_data      (rs1_data_p1),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs1)
    );

    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .src_addr      (rs2_p1),
        .reg_data      (rs2_data_p1),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2)
    );

    assign alu_data_1    = (op1_sel_p1 == OP1_PC)  ? pc_p1  : fwd_rs1;
    assign alu_data_2    = (op2_sel_p1 == OP2_IMM) ? imm_p1 : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_ctrl      = alu_ctrl_p1;
    assign ex_valid      = vld_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_rd         = rd_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, operand select, forwarding priority,
// load-use stall, flush-over-stall and pipeline hold.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_in, flush_in;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_ctrl;
    logic        id_op1_sel, id_op2_sel;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_out;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_data_1, alu_data_2, ex_store_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .hold_in(hold_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_ctrl(id_alu_ctrl), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_out(stall_out), .alu_ctrl(alu_ctrl),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hold_in = 0; flush_in = 0;
        id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_alu_ctrl = 4'd0; id_op1_sel = 0; id_op2_sel = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    // ALU-type instruction: rd = rs1 op rs2
    task automatic drive_alu(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
        id_valid = 1; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
        id_alu_ctrl = op; id_op1_sel = 0; id_op2_sel = 0;
        id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2; id_rd = rd;
        id_imm = 0; id_pc = 0;
    endtask

    task automatic drive_lw(input logic [4:0] rd);
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_mem_write = 0;
        id_alu_ctrl = 4'd0; id_op1_sel = 0; id_op2_sel = 1;
        id_rs1 = 5'd2; id_rs1_data = 32'h1000; id_rs2 = 0; id_rs2_data = 0;
        id_imm = 32'd4; id_rd = rd; id_pc = 0;
    endtask

    task automatic test_reset();
        drive_alu(4'd1, 5'd3, 32'h9, 5'd4, 32'h2, 5'd7);
        tick();
        total_cnt++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || alu_ctrl !== 4'd1) $display("FAIL reset_preload ex_valid=%0b ex_rd=%0d alu_ctrl=%0d required 1/7/1", ex_valid, ex_rd, alu_ctrl);
        else pass_cnt++;
        #2 rst = 1;
        #1;
        total_cnt++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0 || ex_rd !== 5'd0)
            $display("FAIL reset_ctrl got %b rd=%0d required 0000 rd=0", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, ex_rd);
        else pass_cnt++;
        total_cnt++;
        if (alu_ctrl !== 4'd0 || stall_out !== 1'b0) $display("FAIL reset_alu alu_ctrl=%0d stall=%0b required 0/0", alu_ctrl, stall_out);
        else pass_cnt++;
        total_cnt++;
        if (alu_data_1 !== 32'd0 || alu_data_2 !== 32'd0 || ex_store_data !== 32'd0)
            $display("FAIL reset_data got %h %h %h required 0", alu_data_1, alu_data_2, ex_store_data);
        else pass_cnt++;
        clear_inputs();
        tick();
        rst = 0;
        tick();
        total_cnt++;
        if (ex_valid !== 1'b0) $display("FAIL reset_no_reissue ex_valid=%0b required 0", ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_plain_add();
        drive_alu(4'd0, 5'd5, 32'd7, 5'd6, 32'd3, 5'd10);
        tick();
        total_cnt++;
        if (alu_data_1 !== 32'd7 || alu_data_2 !== 32'd3 || alu_ctrl !== 4'd0)
            $display("FAIL add_operands got d1=%0d d2=%0d ctrl=%0d required 7/3/0", alu_data_1, alu_data_2, alu_ctrl);
        else pass_cnt++;
        total_cnt++;
        if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd !== 5'd10 || ex_store_data !== 32'd3)
            $display("FAIL add_ctrl got v=%0b w=%0b rd=%0d st=%0d required 1/1/10/3", ex_valid, ex_reg_write, ex_rd, ex_store_data);
        else pass_cnt++;
        // PC + immediate operands; store data still the rs2 value
        id_op1_sel = 1; id_op2_sel = 1; id_pc = 32'h40; id_imm = 32'h100; id_alu_ctrl = 4'd7;
        tick();
        total_cnt++;
        if (alu_data_1 !== 32'h40 || alu_data_2 !== 32'h100 || ex_store_data !== 32'd3 || alu_ctrl !== 4'd7)
            $display("FAIL sel_pc_imm got %h %h %h ctrl=%0d required 40/100/3/7", alu_data_1, alu_data_2, ex_store_data, alu_ctrl);
        else pass_cnt++;
    endtask

    task automatic test_forward_priority();
        drive_alu(4'd0, 5'd5, 32'd7, 5'd6, 32'd3, 5'd10);
        tick();
        exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'h11;
        wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'h22;
        #1;
        total_cnt++;
        if (alu_data_1 !== 32'h11) $display("FAIL fwd_exm got %h required 11", alu_data_1);
        else pass_cnt++;
        exm_reg_write = 0;
        #1;
        total_cnt++;
        if (alu_data_1 !== 32'h22) $display("FAIL fwd_wb got %h required 22", alu_data_1);
        else pass_cnt++;
        wb_reg_write = 0;
        #1;
        total_cnt++;
        if (alu_data_1 !== 32'd7) $display("FAIL fwd_none got %h required 7", alu_data_1);
        else pass_cnt++;
        exm_reg_write = 1; exm_rd = 5'd6; exm_result = 32'h66;
        #1;
        total_cnt++;
        if (alu_data_2 !== 32'h66 || ex_store_data !== 32'h66 || alu_data_1 !== 32'd7)
            $display("FAIL fwd_rs2 got d2=%h st=%h d1=%h required 66/66/7", alu_data_2, ex_store_data, alu_data_1);
        else pass_cnt++;
        // x0 source with x0 writers: never forwarded, reads zero
        drive_alu(4'd0, 5'd0, 32'h55, 5'd6, 32'd3, 5'd10);
        exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'h11;
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h22;
        tick();
        total_cnt++;
        if (alu_data_1 !== 32'd0) $display("FAIL fwd_x0 got %h required 0", alu_data_1);
        else pass_cnt++;
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        drive_lw(5'd5);
        tick();
        drive_alu(4'd0, 5'd5, 32'h0, 5'd6, 32'd3, 5'd7);
        #1;
        total_cnt++;
        if (stall_out !== 1'b1) $display("FAIL lu_stall got %0b required 1", stall_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || stall_out !== 1'b0)
            $display("FAIL lu_bubble got v=%0b mr=%0b stall=%0b required 0/0/0", ex_valid, ex_mem_read, stall_out);
        else pass_cnt++;
        exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'h1004;
        tick();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hDEAD;
        #1;
        total_cnt++;
        if (alu_data_1 !== 32'hDEAD || ex_valid !== 1'b1 || ex_rd !== 5'd7 || stall_out !== 1'b0)
            $display("FAIL lu_fwd got d1=%h v=%0b rd=%0d stall=%0b required DEAD/1/7/0", alu_data_1, ex_valid, ex_rd, stall_out);
        else pass_cnt++;
        clear_inputs();
        tick();
    endtask

    task automatic test_flush_vs_stall();
        drive_lw(5'd5);
        tick();
        drive_alu(4'd1, 5'd8, 32'h1, 5'd5, 32'h2, 5'd9);
        flush_in = 1;
        #1;
        total_cnt++;
        if (stall_out !== 1'b0) $display("FAIL flush_stall got %0b required 0", stall_out);
        else pass_cnt++;
        tick();
        flush_in = 0;
        total_cnt++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || alu_ctrl !== 4'd0)
            $display("FAIL flush_bubble got v=%0b w=%0b rd=%0d ctrl=%0d required 0/0/0/0", ex_valid, ex_reg_write, ex_rd, alu_ctrl);
        else pass_cnt++;
        clear_inputs();
        tick();
    endtask

    task automatic test_hold();
        drive_alu(4'd1, 5'd3, 32'h33, 5'd4, 32'h1, 5'd9);
        tick();
        hold_in = 1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(4'd2, 5'd3, 32'h44 + i, 5'd4, 32'h2, 5'd12 + 5'(i));
            tick();
            total_cnt++;
            if (ex_rd !== 5'd9 || alu_ctrl !== 4'd1 || alu_data_1 !== 32'h33)
                $display("FAIL hold_cycle%0d got rd=%0d ctrl=%0d d1=%h required 9/1/33", i, ex_rd, alu_ctrl, alu_data_1);
            else pass_cnt++;
        end
        drive_alu(4'd3, 5'd3, 32'h55, 5'd4, 32'h3, 5'd13);
        hold_in = 0;
        tick();
        total_cnt++;
        if (ex_rd !== 5'd13 || alu_ctrl !== 4'd3 || alu_data_1 !== 32'h55)
            $display("FAIL hold_release got rd=%0d ctrl=%0d d1=%h required 13/3/55", ex_rd, alu_ctrl, alu_data_1);
        else pass_cnt++;
        // hold over a load-use: stall suppressed, then re-evaluated
        drive_lw(5'd5);
        tick();
        drive_alu(4'd0, 5'd5, 32'h0, 5'd6, 32'd3, 5'd7);
        hold_in = 1;
        #1;
        total_cnt++;
        if (stall_out !== 1'b0) $display("FAIL hold_lu_stall got %0b required 0", stall_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5) $display("FAIL hold_lu_frozen got mr=%0b rd=%0d required 1/5", ex_mem_read, ex_rd);
        else pass_cnt++;
        hold_in = 0;
        #1;
        total_cnt++;
        if (stall_out !== 1'b1) $display("FAIL hold_lu_release got %0b required 1", stall_out);
        else pass_cnt++;
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        test_reset();
        test_plain_add();
        test_forward_priority();
        test_load_use();
        test_flush_vs_stall();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
